// File: rtl/split_access_unit.sv
// split_access_unit: load/store front-end that turns byte, half and word
// accesses at any byte address into one or two word-aligned memory accesses.
// A boundary-crossing access is split, and the two returned words are merged
// before alignment and sign/zero extension. One response is returned per request.
// Optional feature: define SPLIT_ACCESS_FAULT_EN to add the access_fault output
// and suppress accesses that are illegal, out of DATA_BEGIN..DATA_END, or wrap.
module split_access_unit #(
  parameter int ADDR_W = 32
`ifdef SPLIT_ACCESS_FAULT_EN
  ,
  parameter logic [ADDR_W-1:0] DATA_BEGIN = '0,
  parameter logic [ADDR_W-1:0] DATA_END   = '1
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [2:0]        data_format,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-3:0] mem_address,
  output logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
`ifdef SPLIT_ACCESS_FAULT_EN
  ,
  output logic              access_fault
`endif
);

  localparam int WA = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  state_t         state;
  logic [WA-1:0]  addr_word_q;
  logic [1:0]     off_q;
  logic [2:0]     fmt_q;
  logic           rd_q;
  logic           wr_q;
  logic           split_q;
  logic [3:0]     hi_be_q;
  logic [31:0]    hi_wd_q;
  logic [31:0]    lo_word_q;

  logic [3:0]     base_mask;
  logic [7:0]     mask8;
  logic [63:0]    wd64;
  logic           legal;
  logic           in_split;
  logic           in_fault;
  logic           go_rd;
  logic           go_wr;
  logic [31:0]    lo_word;
  logic [31:0]    shifted;
  logic [31:0]    extended;

  // Decode the incoming request into lane masks, positioned store data and the operation to issue
  always_comb begin
    base_mask = 4'b0001;
    case (data_format[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask8    = {4'b0000, base_mask} << address[1:0];
    wd64     = {32'b0, write_data} << {address[1:0], 3'b000};
    legal    = (data_format[1:0] != 2'b11);
    in_split = legal && (mask8[7:4] != 4'b0000);
    go_wr    = legal && write_enable && !in_fault;
    go_rd    = legal && read_enable && !write_enable && !in_fault;
  end

`ifdef SPLIT_ACCESS_FAULT_EN
  logic [ADDR_W:0] last_byte;
  logic [1:0]      size_m1;
  logic            fault_q;

  // Flag illegal formats, accesses outside the data window and accesses wrapping the address space
  always_comb begin
    size_m1 = 2'd0;
    case (data_format[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    last_byte = {1'b0, address} + (ADDR_W+1)'(size_m1);
    in_fault  = !legal || last_byte[ADDR_W] || (address < DATA_BEGIN) ||
                (last_byte[ADDR_W-1:0] > DATA_END);
  end
`else
  assign in_fault = 1'b0;
`endif

  // Merge the two returned words, align to the requested byte, then extend by format
  always_comb begin
    lo_word  = split_q ? lo_word_q : mem_read_data;
    shifted  = 32'({mem_read_data, lo_word} >> {off_q, 3'b000});
    extended = 32'b0;
    case (fmt_q[1:0])
      2'b00:   extended = {{24{~fmt_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   extended = {{16{~fmt_q[2] & shifted[15]}}, shifted[15:0]};
      2'b10:   extended = shifted;
      default: extended = 32'b0;
    endcase
    read_data = (resp_valid && rd_q) ? extended : 32'b0;
  end

  // Sequencer: IDLE -> LOW -> (HIGH when split) -> RESP, with all handshake and memory outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_byte_enable  <= 4'b0;
      mem_write_data   <= 32'b0;
      addr_word_q      <= '0;
      off_q            <= 2'b0;
      fmt_q            <= 3'b0;
      rd_q             <= 1'b0;
      wr_q             <= 1'b0;
      split_q          <= 1'b0;
      hi_be_q          <= 4'b0;
      hi_wd_q          <= 32'b0;
      lo_word_q        <= 32'b0;
`ifdef SPLIT_ACCESS_FAULT_EN
      fault_q          <= 1'b0;
      access_fault     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state            <= LOW;
            req_ready        <= 1'b0;
            addr_word_q      <= address[ADDR_W-1:2];
            off_q            <= address[1:0];
            fmt_q            <= data_format;
            rd_q             <= go_rd;
            wr_q             <= go_wr;
            split_q          <= in_split;
            hi_be_q          <= mask8[7:4];
            hi_wd_q          <= wd64[63:32];
`ifdef SPLIT_ACCESS_FAULT_EN
            fault_q          <= in_fault;
`endif
            mem_read_enable  <= go_rd;
            mem_write_enable <= go_wr;
            mem_address      <= (go_rd || go_wr) ? address[ADDR_W-1:2] : '0;
            mem_byte_enable  <= (go_rd || go_wr) ? mask8[3:0] : 4'b0;
            mem_write_data   <= go_wr ? wd64[31:0] : 32'b0;
          end
        end
        LOW: begin
          if (split_q) begin
            state           <= HIGH;
            mem_address     <= (rd_q || wr_q) ? addr_word_q + WA'(1) : '0;
            mem_byte_enable <= (rd_q || wr_q) ? hi_be_q : 4'b0;
            mem_write_data  <= wr_q ? hi_wd_q : 32'b0;
          end else begin
            state            <= RESP;
            resp_valid       <= 1'b1;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_byte_enable  <= 4'b0;
            mem_write_data   <= 32'b0;
`ifdef SPLIT_ACCESS_FAULT_EN
            access_fault     <= fault_q;
`endif
          end
        end
        HIGH: begin
          state            <= RESP;
          resp_valid       <= 1'b1;
          lo_word_q        <= mem_read_data;
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_address      <= '0;
          mem_byte_enable  <= 4'b0;
          mem_write_data   <= 32'b0;
`ifdef SPLIT_ACCESS_FAULT_EN
          access_fault     <= fault_q;
`endif
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
`ifdef SPLIT_ACCESS_FAULT_EN
          access_fault <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_access_unit.sv
// tb_split_access_unit: directed and randomized checks of split_access_unit
// against a byte-addressed reference memory model. A word-organised memory
// model answers the DUT's strobes with one cycle of read latency.
module tb_split_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  data_format = 3'b0;
  logic [31:0] address = 32'b0;
  logic [31:0] write_data = 32'b0;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [29:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_write_data;
  logic [31:0] memReadData = 32'b0;
`ifdef SPLIT_ACCESS_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
  logic        access_fault;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  split_access_unit dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .read_enable(read_enable), .write_enable(write_enable), .data_format(data_format),
    .address(address), .write_data(write_data), .resp_valid(resp_valid),
    .read_data(read_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_read_data(memReadData)
`ifdef SPLIT_ACCESS_FAULT_EN
    , .access_fault(access_fault)
`endif
  );

  always #5 clock = ~clock;

  int vectorsApplied = 0;
  int miscompares = 0;

  logic [31:0] wordMem [bit [29:0]];
  logic [7:0]  refMem [bit [31:0]];

  int cycle = 0;
  int acceptCycle = 0;
  int acceptCount = 0;
  int rdCount = 0;
  int wrCount = 0;
  int bothCount = 0;
  logic [29:0] accAddrQ[$];
  logic [3:0]  accBeQ[$];
  logic [31:0] accWdQ[$];
  int preReq = 0;
  int preAck = 0;
  logic [29:0] preAddr = 30'b0;
  logic [31:0] preData = 32'b0;
  int accBase = 0;

  function automatic logic [31:0] readWord(input logic [29:0] a);
    if (wordMem.exists(a)) return wordMem[a];
    return 32'b0;
  endfunction

  function automatic logic [7:0] refByte(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return 8'b0;
  endfunction

  // Word memory and bus observer: answers strobes, logs accesses, counts edges and accepts
  always @(posedge clock) begin
    logic [31:0] tmp;
    if (reset_n && req_valid && req_ready) begin
      acceptCycle = cycle;
      acceptCount++;
    end
    cycle++;
    if (preReq != preAck) begin
      wordMem[preAddr] = preData;
      preAck = preReq;
    end
    if (mem_read_enable && mem_write_enable) bothCount++;
    if (mem_read_enable || mem_write_enable) begin
      accAddrQ.push_back(mem_address);
      accBeQ.push_back(mem_byte_enable);
      accWdQ.push_back(mem_write_data);
    end
    if (mem_read_enable) begin
      rdCount++;
      memReadData <= readWord(mem_address);
    end
    if (mem_write_enable) begin
      wrCount++;
      tmp = readWord(mem_address);
      for (int i = 0; i < 4; i++)
        if (mem_byte_enable[i]) tmp[8*i +: 8] = mem_write_data[8*i +: 8];
      wordMem[mem_address] = tmp;
    end
  end

  // Bounds the whole run in case the DUT stalls somewhere unexpected
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, required completion before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic int fmtSize(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit isFault(input logic [2:0] f, input logic [31:0] a);
    logic [63:0] last;
    if (f[1:0] == 2'b11) return 1'b1;
    last = {32'b0, a} + 64'(fmtSize(f) - 1);
    return FAULT_EN && (last > 64'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'b0;
    n = fmtSize(f);
    for (int i = 0; i < n; i++) v[8*i +: 8] = refByte(a + 32'(i));
    if (n == 1 && !f[2] && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !f[2] && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] a, input int count, input logic [31:0] wd);
    for (int i = 0; i < count; i++) refMem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic preload(input logic [29:0] wa, input logic [31:0] v);
    preAddr = wa;
    preData = v;
    preReq++;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) refMem[{wa, 2'(i)}] = v[8*i +: 8];
  endtask

  task automatic waitAccept(input int target, output bit ok);
    int waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (acceptCount < target && waited < 20);
    ok = (acceptCount >= target);
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResp(output bit ok);
    int waited = 0;
    while (!resp_valid && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    ok = resp_valid;
    if (!ok) checkOutput("resp_timeout", 32'd0, 32'd1);
  endtask

  // One complete request: drive, wait for accept and response, compare against the model
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] fmt,
                               input logic [31:0] addr, input logic [31:0] wd);
    int n, prev, rdBase, wrBase;
    bit legal, split, fault, isRd, isWr, ok;
    logic [31:0] expData;
    n = fmtSize(fmt);
    legal = (fmt[1:0] != 2'b11);
    split = legal && (int'(addr[1:0]) + n > 4);
    fault = isFault(fmt, addr);
    isWr = wr && !fault;
    isRd = rd && !wr && !fault;
    expData = isRd ? modelLoad(fmt, addr) : 32'b0;
    @(negedge clock);
    rdBase = rdCount;
    wrBase = wrCount;
    accBase = accAddrQ.size();
    prev = acceptCount;
    read_enable = rd;
    write_enable = wr;
    data_format = fmt;
    address = addr;
    write_data = wd;
    req_valid = 1'b1;
    waitAccept(prev + 1, ok);
    req_valid = 1'b0;
    if (!ok) return;
    waitResp(ok);
    if (!ok) return;
    checkOutput("latency", 32'(cycle - acceptCycle), split ? 32'd3 : 32'd2);
    checkOutput("read_data", read_data, expData);
    checkOutput("rd_strobes", 32'(rdCount - rdBase), isRd ? (split ? 32'd2 : 32'd1) : 32'd0);
    checkOutput("wr_strobes", 32'(wrCount - wrBase), isWr ? (split ? 32'd2 : 32'd1) : 32'd0);
`ifdef SPLIT_ACCESS_FAULT_EN
    checkOutput("access_fault", {31'b0, access_fault}, {31'b0, fault});
`endif
    if (isWr) modelStore(addr, n, wd);
    @(negedge clock);
    checkOutput("resp_pulse", {31'b0, resp_valid}, 32'd0);
    checkOutput("ready_after", {31'b0, req_ready}, 32'd1);
    checkOutput("read_data_idle", read_data, 32'd0);
  endtask

  initial begin
    bit ok;
    int prev, r1, wrBase;
    logic [31:0] a;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_rdata", read_data, 32'd0);
    checkOutput("rst_strobes", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
    checkOutput("rst_maddr", {2'b0, mem_address}, 32'd0);
    checkOutput("rst_be_wd", {28'b0, mem_byte_enable} | mem_write_data, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Byte loads, unsigned then signed
    preload(30'h800, 32'hAABB_CCDD);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'b0);
    checkOutput("ub_addr", {2'b0, accAddrQ[accBase]}, 32'h800);
    checkOutput("ub_be", {28'b0, accBeQ[accBase]}, 32'b1000);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'b0);

    // Split word store
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h1122_3344);
    checkOutput("st_lo_addr", {2'b0, accAddrQ[accBase]}, 32'h800);
    checkOutput("st_lo_be", {28'b0, accBeQ[accBase]}, 32'b1100);
    checkOutput("st_lo_wd", accWdQ[accBase], 32'h3344_0000);
    checkOutput("st_hi_addr", {2'b0, accAddrQ[accBase+1]}, 32'h801);
    checkOutput("st_hi_be", {28'b0, accBeQ[accBase+1]}, 32'b0011);
    checkOutput("st_hi_wd", accWdQ[accBase+1], 32'h0000_1122);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'b0);

    // Split signed half load
    preload(30'h800, 32'h80FF_FFFF);
    preload(30'h801, 32'h0000_00FF);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_2003, 32'b0);
    checkOutput("sh_value", modelLoad(3'b001, 32'h0000_2003), 32'hFFFF_FF80);

    // Word load wrapping the top of the address space
    preload(30'h3FFF_FFFF, 32'h1234_5678);
    preload(30'h0, 32'h9ABC_DEF0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFD, 32'b0);
`ifndef SPLIT_ACCESS_FAULT_EN
    checkOutput("wrap_hi_addr", {2'b0, accAddrQ[accBase+1]}, 32'd0);
`endif

    // Reset during the high half of a split store
    preload(30'h900, 32'hA0B0_C0D0);
    preload(30'h901, 32'hE0F0_1020);
    @(negedge clock);
    wrBase = wrCount;
    prev = acceptCount;
    read_enable = 1'b0;
    write_enable = 1'b1;
    data_format = 3'b010;
    address = 32'h0000_2402;
    write_data = 32'hCAFE_BABE;
    req_valid = 1'b1;
    waitAccept(prev + 1, ok);
    req_valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr", {31'b0, mem_write_enable}, 32'd0);
    checkOutput("mid_rst_maddr", {2'b0, mem_address}, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    modelStore(32'h0000_2402, 2, 32'hCAFE_BABE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("mid_rst_noresp", {31'b0, resp_valid}, 32'd0);
    end
    checkOutput("mid_rst_wrcount", 32'(wrCount - wrBase), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_ready", {31'b0, req_ready}, 32'd1);
    preload(30'h1, 32'h0BAD_F00D);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_2400, 32'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_2404, 32'b0);

    // Back-to-back requests with req_valid held high
    preload(30'h10, 32'h0102_0304);
    preload(30'h11, 32'h0506_0708);
    @(negedge clock);
    prev = acceptCount;
    read_enable = 1'b1;
    write_enable = 1'b0;
    data_format = 3'b010;
    address = 32'h0000_0040;
    req_valid = 1'b1;
    waitAccept(prev + 1, ok);
    address = 32'h0000_0044;
    waitResp(ok);
    r1 = cycle;
    checkOutput("b2b_data1", read_data, modelLoad(3'b010, 32'h0000_0040));
    waitAccept(prev + 2, ok);
    req_valid = 1'b0;
    checkOutput("b2b_gap", 32'(acceptCycle - r1), 32'd1);
    waitResp(ok);
    checkOutput("b2b_data2", read_data, modelLoad(3'b010, 32'h0000_0044));
    @(negedge clock);

    // Illegal format and no-op requests
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'b0);
    applyStimulus(1'b0, 1'b1, 3'b111, 32'h0000_2001, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 3'b001, 32'h0000_2003, 32'b0);

    // Randomized mix of formats, operations and alignments, including the wrap region
    for (int t = 0; t < 250; t++) begin
      logic [1:0] op;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h0000_3000 + 32'($urandom_range(0, 47));
      op = 2'($urandom_range(0, 3));
      applyStimulus(op[0], op[1], 3'($urandom_range(0, 7)), a, $urandom);
    end

    checkOutput("both_strobes", 32'(bothCount), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/split_access_unit.md
Name: split_access_unit

Overview:
- Sequential load/store front-end between the core's memory stage and the word-organised data memory.
- Accepts byte, half and word accesses at any byte address and issues one or two word-aligned memory accesses with byte enables.
- Accesses that cross a 32-bit word boundary are split into two accesses, and the two returned words are merged before alignment and sign/zero extension.
- Returns a single response per request.

Parameters:
- ADDR_W, 32, byte address width; memory word address is ADDR_W-2 bits and wraps modulo 2^(ADDR_W-2).

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept
- read_enable  input  1  load request (ignored if write_enable=1)
- write_enable  input  1  store request
- data_format  input  3  [1:0]: 00 byte, 01 half, 10 word, 11 illegal; [2]=1 unsigned load
- address  input  ADDR_W  byte address
- write_data  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- read_data  output  32  aligned, extended load result; 0 when resp_valid=0 or for stores
- mem_read_enable  output  1  memory read strobe
- mem_write_enable  output  1  memory write strobe
- mem_address  output  ADDR_W-2  word address
- mem_byte_enable  output  4  byte lanes for the current access
- mem_write_data  output  32  lane-positioned store data
- mem_read_data  input  32  synchronous memory output; valid the cycle after a read strobe

Behaviour:
- Reset is asynchronous on reset_n low: state IDLE, req_ready=1, resp_valid=0, read_data=0, all mem_* outputs 0, internal registers cleared.
- Reset mid-operation aborts the request with no response. Any memory write already strobed stays committed.
- Accept: req_valid & req_ready on an edge registers address, format, operation and write_data. req_ready=1 only in IDLE.
- Request with neither read_enable nor write_enable set is a no-op: no mem strobe; resp_valid is still produced at accept+2, with read_data=0.
- Size n is 1, 2 or 4 bytes; o = address[1:0]. 8-bit mask = ((1<<n)-1) << o. lo_be=mask[3:0], hi_be=mask[7:4]. split = (hi_be != 0).
- Store data: wd64 = {32'b0, write_data} << 8*o. Low access uses wd64[31:0]; high access uses wd64[63:32].
- FSM states IDLE -> LOW -> (HIGH if split) -> RESP -> IDLE.
- LOW: mem_address = address[ADDR_W-1:2], byte enables lo_be, strobe asserted per operation.
- HIGH: mem_address = address word + 1, wrapping to 0 from all-ones. Byte enables hi_be. The low read word is captured from mem_read_data.
- RESP: resp_valid=1 for exactly one cycle. lo = split ? captured word : mem_read_data; hi = mem_read_data. r = {hi,lo} >> 8*o.
- RESP extension: byte -> {24{~fmt[2]&r[7]},r[7:0]}; half -> {16{~fmt[2]&r[15]},r[15:0]}; word -> r[31:0].
- Latency from the accept edge to resp_valid: 2 cycles unsplit, 3 cycles split. Throughput: one request per 3 cycles unsplit, 4 split. The next accept is possible in the cycle after RESP.
- Illegal format 11: no mem strobes, resp_valid at accept+2, read_data=0.
- mem_* outputs are 0 in IDLE and RESP.
- mem_read_enable and mem_write_enable are never both 1.
- Byte, and any access with o=0, never splits.

Optional Feature:
- Macro: SPLIT_ACCESS_FAULT_EN.
- Defined: adds output access_fault (1 bit), asserted only with resp_valid.
- Fault when format is 11, when any touched byte lies outside DATA_BEGIN..DATA_END, or when the last touched byte wraps past the top of the address space.
- On a fault, both memory strobes are suppressed (no partial write) and read_data=0. Timing is unchanged.
- Undefined: no access_fault port. Every legal-format access is issued as described.

Test Plan:
- Unsigned-byte load at 0x00002003 with memory word 0xAABBCCDD at word 0x800 -> one read, mem_byte_enable=1000, resp_valid at accept+2, read_data=0x000000AA. Signed byte at the same address -> 0xFFFFFFAA.
- Word store 0x11223344 at 0x00002002 -> low access word 0x800, be=1100, data=0x33440000. High access word 0x801, be=0011, data=0x00001122. No resp before accept+3.
- Signed half load at 0x00002003 with word 0x800=0x80FFFFFF and 0x801=0x000000FF -> two reads, read_data=0xFFFFFF80, resp_valid at accept+3.
- Word load at 0xFFFFFFFD -> high access mem_address wraps to 0. With SPLIT_ACCESS_FAULT_EN defined -> no strobes and access_fault=1.
- reset_n low during HIGH of a split store -> outputs 0 immediately, no resp_valid. After release, req_ready=1 and a new word load at 0x4 completes normally.
- Back-to-back req_valid held high -> second accept occurs exactly the cycle after resp_valid. Format 11 -> resp_valid, read_data=0, no mem strobes.
